// File: rtl/cw305_reg_bus_master_pkg.sv
// Shared definitions for the CW305 register-bus master: FSM state encoding and
// the minimum number of cycles reg_addrvalid stays low between commands.
package cw305_reg_master_defines;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RD_HOLD  = 3'd4,
        FINISH   = 3'd5
    } state_t;

    localparam logic [3:0] MIN_IDLE_CYCLES = 4'd1;

endpackage

// File: rtl/cw305_reg_bus_master_if.sv
// Command, byte-stream and register-bus signals of the CW305 register-bus master.
// master = the bus master block, slave = whatever drives commands and models the register file.
interface cw305_reg_bus_if #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 8
);
    localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_write;
    logic [AW-1:0]            cmd_addr;
    logic [pBYTECNT_SIZE:0]   cmd_len;
    logic [7:0]               wr_data;
    logic                     wr_valid;
    logic                     wr_ready;
    logic [7:0]               rd_data;
    logic                     rd_valid;
    logic                     rd_ready;
    logic                     abort;
    logic                     busy;
    logic                     done;
    logic [AW-1:0]            reg_address;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
    logic [7:0]               write_data;
    logic [7:0]               read_data;
    logic                     reg_read;
    logic                     reg_write;
    logic                     reg_addrvalid;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid,
               rd_ready, abort, read_data,
        output cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
               reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid,
               rd_ready, abort, read_data,
        input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
               reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid
    );

endinterface

// File: rtl/cw305_reg_bus_master.sv
// Turns write/read commands into CW305 register-bus strobes; writes sustain 1 byte/cycle
// (strobe one cycle after accept), reads take 3 cycles per byte and stall on rd_ready.
module cw305_reg_bus_master
    import cw305_reg_master_defines::*;
#(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 8
)(
    input  logic            usb_clk,
    input  logic            reset_i,
    cw305_reg_bus_if.master bus
);

    localparam int BC = pBYTECNT_SIZE;
    localparam logic [BC:0]   LEN_ONE = 1;
    localparam logic [BC-1:0] IDX_ONE = 1;

    state_t        state;
    logic [BC:0]   len_r;
    logic [BC-1:0] idx;
    logic [3:0]    fin_cnt;
    logic          idx_last;

    // The index stops at len-1, so a full 2^BC transfer ends on all-ones without wrapping.
    assign idx_last = ({1'b0, idx} == (len_r - LEN_ONE));

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            state             <= IDLE;
            len_r             <= '0;
            idx               <= '0;
            fin_cnt           <= '0;
            bus.cmd_ready     <= 1'b0;
            bus.wr_ready      <= 1'b0;
            bus.rd_data       <= '0;
            bus.rd_valid      <= 1'b0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.reg_address   <= '0;
            bus.reg_bytecnt   <= '0;
            bus.write_data    <= '0;
            bus.reg_read      <= 1'b0;
            bus.reg_write     <= 1'b0;
            bus.reg_addrvalid <= 1'b0;
        end else if (bus.abort && state != IDLE) begin
            state             <= IDLE;
            bus.cmd_ready     <= 1'b1;
            bus.wr_ready      <= 1'b0;
            bus.rd_data       <= '0;
            bus.rd_valid      <= 1'b0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.reg_read      <= 1'b0;
            bus.reg_write     <= 1'b0;
            bus.reg_addrvalid <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.cmd_ready   <= 1'b0;
                        bus.busy        <= 1'b1;
                        bus.reg_address <= bus.cmd_addr;
                        len_r           <= bus.cmd_len;
                        idx             <= '0;
                        if (bus.cmd_len == '0) begin
                            state    <= FINISH;
                            bus.done <= 1'b1;
                            fin_cnt  <= '0;
                        end else if (bus.cmd_write) begin
                            state        <= WR;
                            bus.wr_ready <= 1'b1;
                        end else begin
                            state             <= RD_ISSUE;
                            bus.reg_read      <= 1'b1;
                            bus.reg_addrvalid <= 1'b1;
                            bus.reg_bytecnt   <= '0;
                        end
                    end
                end

                // wr_ready dropping marks that the last byte has been taken.
                WR: begin
                    if (bus.wr_ready) begin
                        if (bus.wr_valid) begin
                            bus.reg_write     <= 1'b1;
                            bus.write_data    <= bus.wr_data;
                            bus.reg_bytecnt   <= idx;
                            bus.reg_addrvalid <= 1'b1;
                            if (idx_last)
                                bus.wr_ready <= 1'b0;
                            else
                                idx <= idx + IDX_ONE;
                        end else begin
                            bus.reg_write <= 1'b0;
                        end
                    end else begin
                        bus.reg_write     <= 1'b0;
                        bus.reg_addrvalid <= 1'b0;
                        bus.done          <= 1'b1;
                        fin_cnt           <= '0;
                        state             <= FINISH;
                    end
                end

                RD_ISSUE: begin
                    bus.reg_read <= 1'b0;
                    state        <= RD_WAIT;
                end

                RD_WAIT: begin
                    bus.rd_data  <= bus.read_data;
                    bus.rd_valid <= 1'b1;
                    state        <= RD_HOLD;
                end

                RD_HOLD: begin
                    if (bus.rd_ready) begin
                        bus.rd_valid <= 1'b0;
                        if (idx_last) begin
                            bus.reg_addrvalid <= 1'b0;
                            bus.done          <= 1'b1;
                            fin_cnt           <= '0;
                            state             <= FINISH;
                        end else begin
                            idx             <= idx + IDX_ONE;
                            bus.reg_bytecnt <= idx + IDX_ONE;
                            bus.reg_read    <= 1'b1;
                            state           <= RD_ISSUE;
                        end
                    end
                end

                // Holding here keeps reg_addrvalid low long enough before the next command.
                FINISH: begin
                    if (fin_cnt == MIN_IDLE_CYCLES - 4'd1) begin
                        bus.cmd_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        fin_cnt <= fin_cnt + 4'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
